// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pkg
// Description : Shared definitions for the bitmap SPI frame loader: command
//               codes, FSM state encoding and status-byte bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

  // Command byte values
  localparam logic [7:0] CMD_WRITE  = 8'hA5;
  localparam logic [7:0] CMD_STATUS = 8'h5A;

  // FSM state encoding
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_CMD      = 4'd1;
  localparam logic [STATE_W-1:0] S_ADDR_H   = 4'd2;
  localparam logic [STATE_W-1:0] S_ADDR_L   = 4'd3;
  localparam logic [STATE_W-1:0] S_LEN_H    = 4'd4;
  localparam logic [STATE_W-1:0] S_LEN_L    = 4'd5;
  localparam logic [STATE_W-1:0] S_DATA     = 4'd6;
  localparam logic [STATE_W-1:0] S_WAIT_END = 4'd7;
  localparam logic [STATE_W-1:0] S_ERR      = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = S_IDLE,
    ST_CMD      = S_CMD,
    ST_ADDR_H   = S_ADDR_H,
    ST_ADDR_L   = S_ADDR_L,
    ST_LEN_H    = S_LEN_H,
    ST_LEN_L    = S_LEN_L,
    ST_DATA     = S_DATA,
    ST_WAIT_END = S_WAIT_END,
    ST_ERR      = S_ERR
  } state_t;

  // Status byte bit positions (remaining bits read as zero)
  localparam int STS_ERR_BIT = 7;
  localparam int STS_OVF_BIT = 6;

  function automatic logic [7:0] status_byte(input logic err, input logic ovf);
    logic [7:0] b;
    b              = 8'h00;
    b[STS_ERR_BIT] = err;
    b[STS_OVF_BIT] = ovf;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmp_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bmp_wr_buffer
// Description : One-entry write buffer between the payload byte stream and
//               the pixel memory write port.
// Revision    : 1.0 - initial release
// Ports       : Clk, Reset_n      clock / async active-low reset
//               i_push, i_data    payload byte offered for buffering
//               i_mem_ready       memory accepts a write this cycle
//               o_we, o_data      registered write request and data
//               o_fire            handshake (o_we & i_mem_ready) this cycle
//               o_overflow        byte offered while full and memory stalled
// ============================================================================
module bmp_wr_buffer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_mem_ready,
  output logic       o_we,
  output logic [7:0] o_data,
  output logic       o_fire,
  output logic       o_overflow
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       w_fire;
  logic       w_accept;

  assign w_fire     = r_valid & i_mem_ready;
  // A drain in the same cycle frees the slot, so refill is lossless.
  assign w_accept   = i_push & (~r_valid | i_mem_ready);
  assign o_overflow = i_push & r_valid & ~i_mem_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign o_we   = r_valid;
  assign o_data = r_data;
  assign o_fire = w_fire;

endmodule
`default_nettype wire

// File: rtl/bmp_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : bmp_spi_loader
// Description : Parses SPI command frames (cmd, 16-bit address, 16-bit count)
//               and turns the payload into single-byte pixel memory writes.
//               Reports status to the host and flags protocol errors.
// Revision    : 1.0 - initial release
// Ports       : Clk, Reset_n          clock / async active-low reset
//               CS_n                  synchronized frame select (low = open)
//               Rx_Byte, Rx_Valid     received byte strobe
//               Mem_Ready             memory accepts a write
//               Mem_We/Addr/Data      memory write request
//               Tx_Byte               status byte for the host
//               Busy, Done, Err       frame status flags
// ============================================================================
module bmp_spi_loader
  import bmp_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CS_n,
  input  logic [7:0]        Rx_Byte,
  input  logic              Rx_Valid,
  input  logic              Mem_Ready,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_Data,
  output logic [7:0]        Tx_Byte,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam int              c_TMR_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT_CYC);

  state_t              r_state;
  logic                r_cs_d;
  logic [7:0]          r_addr_h;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_count;    // writes still to be accepted by memory
  logic [15:0]         r_rx_left;  // payload bytes still to be received
  logic [c_TMR_W-1:0]  r_timer;
  logic                r_err;
  logic                r_ovf;
  logic                r_err_last;
  logic                r_ovf_last;
  logic [7:0]          r_tx;
  logic                r_busy;
  logic                r_done;

  logic                w_cs_fall;
  logic                w_cs_rise;
  logic                w_active;
  logic                w_abort;
  logic                w_timeout;
  logic                w_push;
  logic                w_fire;
  logic                w_ovf;
  logic [15:0]         w_addr16;
  logic [15:0]         w_len16;

  assign w_cs_fall = r_cs_d & ~CS_n;
  assign w_cs_rise = ~r_cs_d & CS_n;
  // Header and payload states: timeout and early-close apply here only.
  assign w_active  = (r_state != ST_IDLE) && (r_state != ST_WAIT_END) &&
                     (r_state != ST_ERR);
  assign w_abort   = w_active & CS_n;
  assign w_timeout = w_active & (r_timer == c_TMR_MAX);
  assign w_push    = (r_state == ST_DATA) & Rx_Valid & ~CS_n & (r_rx_left != 16'd0);
  assign w_addr16  = {r_addr_h, Rx_Byte};
  assign w_len16   = {r_count[15:8], Rx_Byte};

  bmp_wr_buffer u_buf (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_push      (w_push),
    .i_data      (Rx_Byte),
    .i_mem_ready (Mem_Ready),
    .o_we        (Mem_We),
    .o_data      (Mem_Data),
    .o_fire      (w_fire),
    .o_overflow  (w_ovf)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_cs_d     <= 1'b1;
      r_addr_h   <= 8'h00;
      r_addr     <= '0;
      r_count    <= 16'd0;
      r_rx_left  <= 16'd0;
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_err_last <= 1'b0;
      r_ovf_last <= 1'b0;
      r_tx       <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cs_d <= CS_n;
      r_done <= 1'b0;

      if (w_active && !Rx_Valid) r_timer <= r_timer + 1'b1;
      else                       r_timer <= '0;

      // Pending writes drain in any state, including after an abort or error.
      if (w_fire) begin
        r_addr <= r_addr + 1'b1;
        if (r_count != 16'd0) r_count <= r_count - 1'b1;
      end
      if (w_push) r_rx_left <= r_rx_left - 1'b1;

      if (w_cs_rise) begin
        r_err_last <= r_err | w_abort;
        r_ovf_last <= r_ovf;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state <= ST_CMD;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_END, ST_ERR: begin
          if (CS_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          if (CS_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_timeout) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else begin
            case (r_state)
              ST_CMD: if (Rx_Valid) begin
                if (Rx_Byte == CMD_WRITE) begin
                  r_state <= ST_ADDR_H;
                end else if (Rx_Byte == CMD_STATUS) begin
                  r_state <= ST_WAIT_END;
                  r_tx    <= status_byte(r_err_last, r_ovf_last);
                end else begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                end
              end
              ST_ADDR_H: if (Rx_Valid) begin
                r_addr_h <= Rx_Byte;
                r_state  <= ST_ADDR_L;
              end
              ST_ADDR_L: if (Rx_Valid) begin
                r_addr  <= w_addr16[ADDR_W-1:0];
                r_state <= ST_LEN_H;
              end
              ST_LEN_H: if (Rx_Valid) begin
                r_count[15:8] <= Rx_Byte;
                r_state       <= ST_LEN_L;
              end
              ST_LEN_L: if (Rx_Valid) begin
                if (w_len16 == 16'd0) begin
                  r_state <= ST_WAIT_END;
                  r_done  <= 1'b1;
                end else begin
                  r_count   <= w_len16;
                  r_rx_left <= w_len16;
                  r_state   <= ST_DATA;
                end
              end
              ST_DATA: begin
                if (w_ovf) begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                  r_ovf   <= 1'b1;
                end else if (w_fire && (r_count == 16'd1)) begin
                  r_state <= ST_WAIT_END;
                  r_done  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign Mem_Addr = r_addr;
  assign Tx_Byte  = r_tx;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bmp_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_spi_loader
// Description : Directed self-checking bench for bmp_spi_loader. Expected
//               memory writes come from a frame-level model (address + i,
//               wrapped to 16 bits) or hand-written lists for error frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_spi_loader;

  localparam int TMO = 64;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        CS_n;
  logic [7:0]  Rx_Byte;
  logic        Rx_Valid;
  logic        Mem_Ready;
  logic        Mem_We;
  logic [15:0] Mem_Addr;
  logic [7:0]  Mem_Data;
  logic [7:0]  Tx_Byte;
  logic        Busy;
  logic        Done;
  logic        Err;

  bmp_spi_loader #(.ADDR_W(16), .TIMEOUT_CYC(TMO)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .CS_n      (CS_n),
    .Rx_Byte   (Rx_Byte),
    .Rx_Valid  (Rx_Valid),
    .Mem_Ready (Mem_Ready),
    .Mem_We    (Mem_We),
    .Mem_Addr  (Mem_Addr),
    .Mem_Data  (Mem_Data),
    .Tx_Byte   (Tx_Byte),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];        // {addr, data} of writes still expected
  bit          chk_en       = 1'b0;
  bit          done_on_last = 1'b0;
  bit          done_due     = 1'b0;
  int          done_seen    = 0;
  logic [7:0]  pl [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: every memory handshake against the expected list, and
  // Done against "exactly one cycle after the final handshake".
  always @(negedge Clk) begin
    if (chk_en && Reset_n) begin
      check(done_due ? "done_pulse" : "done_quiet", {31'd0, Done}, {31'd0, done_due});
      if (Done) done_seen++;
      done_due = 1'b0;
      if (Mem_We && Mem_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h@%0h required=none", Mem_Data, Mem_Addr);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("write_addr", {16'd0, Mem_Addr}, {16'd0, e[23:8]});
          check("write_data", {24'd0, Mem_Data}, {24'd0, e[7:0]});
          if (exp_q.size() == 0 && done_on_last) done_due = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    Rx_Byte  = b;
    Rx_Valid = 1'b1;
    tick();
    Rx_Valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    tick(2);
  endtask

  task automatic send_header(input logic [15:0] addr, input logic [15:0] len);
    send_gap(8'hA5);
    send_gap(addr[15:8]);
    send_gap(addr[7:0]);
    send_gap(len[15:8]);
    send_gap(len[7:0]);
  endtask

  task automatic open_frame;
    CS_n = 1'b0;
    tick();
  endtask

  task automatic close_frame;
    CS_n = 1'b1;
    tick(3);
  endtask

  // Frame model: byte i of the payload lands at (start + i) mod 2^16.
  task automatic model_frame(input logic [15:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [15:0] a;
      a = addr + 16'(i);
      exp_q.push_back({a, pl[i]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   {31'd0, Mem_We},   32'd0);
    check({tag, "_addr"}, {16'd0, Mem_Addr}, 32'd0);
    check({tag, "_data"}, {24'd0, Mem_Data}, 32'd0);
    check({tag, "_tx"},   {24'd0, Tx_Byte},  32'd0);
    check({tag, "_busy"}, {31'd0, Busy},     32'd0);
    check({tag, "_done"}, {31'd0, Done},     32'd0);
    check({tag, "_err"},  {31'd0, Err},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    CS_n      = 1'b1;
    Rx_Byte   = 8'h00;
    Rx_Valid  = 1'b0;
    Mem_Ready = 1'b1;
    tick(3);
    check_reset_outputs("rst");
    Reset_n = 1'b1;
    tick(2);
    chk_en = 1'b1;

    // 1: plain write, memory always ready
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    model_frame(16'h0010, 3);
    done_on_last = 1'b1;
    done_seen    = 0;
    open_frame();
    check("t1_busy_after_fall", {31'd0, Busy}, 32'd1);
    send_header(16'h0010, 16'd3);
    send(8'h11);
    check("t1_we_latency", {31'd0, Mem_We}, 32'd1);
    check("t1_first_addr", {16'd0, Mem_Addr}, 32'h0010);
    check("t1_first_data", {24'd0, Mem_Data}, 32'h11);
    tick(2);
    send_gap(8'h22);
    send_gap(8'h33);
    tick(3);
    check("t1_done_count", done_seen, 1);
    check("t1_err", {31'd0, Err}, 32'd0);
    check("t1_writes_left", exp_q.size(), 0);
    close_frame();
    check("t1_busy_after_close", {31'd0, Busy}, 32'd0);

    // 2: memory stall, second payload byte overflows
    exp_q.push_back({16'h0010, 8'h11});
    done_on_last = 1'b0;
    done_seen    = 0;
    open_frame();
    send_header(16'h0010, 16'd3);
    Mem_Ready = 1'b0;
    send_gap(8'h11);
    send(8'h22);
    check("t2_err_on_ovf", {31'd0, Err}, 32'd1);
    check("t2_buffer_held", {31'd0, Mem_We}, 32'd1);
    tick(2);
    send_gap(8'h33);
    tick(12);
    Mem_Ready = 1'b1;
    tick(3);
    check("t2_we_dropped", {31'd0, Mem_We}, 32'd0);
    check("t2_writes_left", exp_q.size(), 0);
    check("t2_no_done", done_seen, 0);
    close_frame();
    open_frame();
    check("t2_err_cleared", {31'd0, Err}, 32'd0);
    send(8'h5A);
    check("t2_status_ovf", {24'd0, Tx_Byte}, 32'hC0);
    tick(2);
    close_frame();

    // 3: address wrap at 0xFFFF
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    model_frame(16'hFFFF, 2);
    done_on_last = 1'b1;
    done_seen    = 0;
    open_frame();
    send_header(16'hFFFF, 16'd2);
    send_gap(8'hAA);
    send_gap(8'hBB);
    tick(3);
    check("t3_done_count", done_seen, 1);
    check("t3_err", {31'd0, Err}, 32'd0);
    check("t3_writes_left", exp_q.size(), 0);
    check("t3_next_addr", {16'd0, Mem_Addr}, 32'h0001);
    close_frame();

    // 4: bad command, then STATUS reports it
    done_on_last = 1'b0;
    open_frame();
    send_gap(8'h3C);
    check("t4_bad_cmd_err", {31'd0, Err}, 32'd1);
    check("t4_busy_in_err", {31'd0, Busy}, 32'd1);
    close_frame();
    open_frame();
    check("t4_err_cleared", {31'd0, Err}, 32'd0);
    send(8'h5A);
    check("t4_status", {24'd0, Tx_Byte}, 32'h80);
    tick(2);
    close_frame();
    check("t4_tx_holds", {24'd0, Tx_Byte}, 32'h80);

    // 5: short payload, then timeout
    pl[0] = 8'h01; pl[1] = 8'h02;
    model_frame(16'h0040, 2);
    done_on_last = 1'b0;
    done_seen    = 0;
    open_frame();
    send_header(16'h0040, 16'd5);
    send(8'h01);
    tick(2);
    send(8'h02);
    tick(TMO - 3);
    check("t5_no_early_timeout", {31'd0, Err}, 32'd0);
    tick(8);
    check("t5_timeout_err", {31'd0, Err}, 32'd1);
    check("t5_busy_in_err", {31'd0, Busy}, 32'd1);
    check("t5_writes_left", exp_q.size(), 0);
    check("t5_no_done", done_seen, 0);
    close_frame();

    // 6: reset with a full buffer, then a normal frame
    Mem_Ready = 1'b0;
    open_frame();
    send_header(16'h0020, 16'd4);
    send(8'h77);
    tick(1);
    check("t6_buf_full", {31'd0, Mem_We}, 32'd1);
    chk_en  = 1'b0;
    #3;
    Reset_n = 1'b0;
    CS_n    = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    tick(2);
    Reset_n   = 1'b1;
    Mem_Ready = 1'b1;
    tick(2);
    chk_en = 1'b1;
    check("t6_write_dropped", {31'd0, Mem_We}, 32'd0);
    pl[0] = 8'h5A; pl[1] = 8'h6B;
    model_frame(16'h0100, 2);
    done_on_last = 1'b1;
    done_seen    = 0;
    open_frame();
    send_header(16'h0100, 16'd2);
    send_gap(8'h5A);
    send_gap(8'h6B);
    tick(3);
    check("t6_done_count", done_seen, 1);
    check("t6_err", {31'd0, Err}, 32'd0);
    check("t6_writes_left", exp_q.size(), 0);
    close_frame();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
